param_updn_counter: RTL and testbench

PARAM_UPDN_COUNTER -- requirements
Module: param_updn_counter

---
 rtl/param_updn_counter_if.sv | 27 ++
 rtl/param_updn_counter.sv | 95 +++++++++
 tb/tb_param_updn_counter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/param_updn_counter_if.sv
// Bus bundle for param_updn_counter: count controls in, count and status flags out.
// The master drives the controls; the counter itself is the slave.
interface param_updn_counter_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             ci;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             co;
  logic             ov;
  logic             sat;

  modport master (
    output start, ci, up_dn, clr, load, load_val,
    input  q, tc, co, ov, sat
  );

  modport slave (
    input  start, ci, up_dn, clr, load, load_val,
    output q, tc, co, ov, sat
  );
endinterface

// File: rtl/param_updn_counter.sv
// Cascadable modulo-(MAX+1) up/down counter with clamped load, wrap or saturate mode,
// one-cycle wrap pulse and sticky saturation flag.
module param_updn_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9,
  parameter int MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  param_updn_counter_if.slave  bus
);

  generate
    if ((WIDTH < 1) || (MAX < 1) ||
        (longint'(MAX) > ((64'sd1 <<< WIDTH) - 64'sd1)) ||
        ((MODE != 0) && (MODE != 1))) begin : g_bad_params
      $error("param_updn_counter: illegal WIDTH/MAX/MODE combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
  localparam bit               WRAP_C = (MODE == 0);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ov_q, ov_d;
  logic             sat_q, sat_d;
  logic             step_s;
  logic             at_top_s;
  logic             at_bot_s;
  logic             tc_s;

  assign step_s   = bus.start & bus.ci & ~bus.clr & ~bus.load;
  assign at_top_s = (q_q == MAX_C);
  assign at_bot_s = (q_q == ZERO_C);

  // Next-state: clr beats load beats step; boundary handling depends on MODE.
  always_comb begin
    q_d   = q_q;
    ov_d  = 1'b0;
    sat_d = sat_q;
    if (bus.clr) begin
      q_d   = ZERO_C;
      sat_d = 1'b0;
    end else if (bus.load) begin
      q_d   = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
      sat_d = 1'b0;
    end else if (step_s) begin
      if (bus.up_dn) begin
        if (!at_top_s) begin
          q_d = q_q + ONE_C;
        end else if (WRAP_C) begin
          q_d  = ZERO_C;
          ov_d = 1'b1;
        end else begin
          sat_d = 1'b1;
        end
      end else begin
        if (!at_bot_s) begin
          q_d = q_q - ONE_C;
        end else if (WRAP_C) begin
          q_d  = MAX_C;
          ov_d = 1'b1;
        end else begin
          sat_d = 1'b1;
        end
      end
    end else begin
      q_d = q_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q   <= ZERO_C;
      ov_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ov_q  <= ov_d;
      sat_q <= sat_d;
    end
  end

  // tc and co stay combinational so a cascade chain adds no latency.
  assign tc_s    = (bus.up_dn & at_top_s) | (~bus.up_dn & at_bot_s);
  assign bus.q   = q_q;
  assign bus.tc  = tc_s;
  assign bus.co  = tc_s & bus.start & bus.ci;
  assign bus.ov  = ov_q;
  assign bus.sat = sat_q;

endmodule

// File: tb/tb_param_updn_counter.sv
// Directed self-checking bench: wrap, saturate, load priority, cascade, full-range and reset.
module tb_param_updn_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   ov_cnt;
  logic [3:0] exp_q;

  always #5 clk = ~clk;

  param_updn_counter_if #(.WIDTH(4)) b0  ();
  param_updn_counter_if #(.WIDTH(4)) bs  ();
  param_updn_counter_if #(.WIDTH(4)) bc0 ();
  param_updn_counter_if #(.WIDTH(4)) bc1 ();
  param_updn_counter_if #(.WIDTH(4)) bf  ();

  assign bc1.ci = bc0.co;

  param_updn_counter #(.WIDTH(4), .MAX(9),  .MODE(0)) u0     (.clk(clk), .rst(rst), .bus(b0));
  param_updn_counter #(.WIDTH(4), .MAX(9),  .MODE(1)) u_sat  (.clk(clk), .rst(rst), .bus(bs));
  param_updn_counter #(.WIDTH(4), .MAX(9),  .MODE(0)) u_c0   (.clk(clk), .rst(rst), .bus(bc0));
  param_updn_counter #(.WIDTH(4), .MAX(9),  .MODE(0)) u_c1   (.clk(clk), .rst(rst), .bus(bc1));
  param_updn_counter #(.WIDTH(4), .MAX(15), .MODE(0)) u_full (.clk(clk), .rst(rst), .bus(bf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b0.load = 1'b1; b0.load_val = 4'd7; b0.start = 1'b1; b0.up_dn = 1'b1;
    tick(); tick();
    b0.load = 1'b0; b0.start = 1'b0;
    #1;
    n_vec++; if (b0.q !== 4'd0) begin n_err++; $display("FAIL reset_q got %0d want 0", b0.q); end
    n_vec++; if (b0.ov !== 1'b0) begin n_err++; $display("FAIL reset_ov got %b want 0", b0.ov); end
    n_vec++; if (bs.sat !== 1'b0) begin n_err++; $display("FAIL reset_sat got %b want 0", bs.sat); end
    n_vec++; if (b0.tc !== 1'b0) begin n_err++; $display("FAIL reset_tc_up got %b want 0", b0.tc); end
    b0.up_dn = 1'b0;
    #1;
    n_vec++; if (b0.tc !== 1'b1) begin n_err++; $display("FAIL reset_tc_dn got %b want 1", b0.tc); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_wrap_up();
    b0.start = 1'b1; b0.ci = 1'b1; b0.up_dn = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      exp_q = 4'(i % 10);
      n_vec++; if (b0.q !== exp_q) begin n_err++; $display("FAIL wrap_up_q[%0d] got %0d want %0d", i, b0.q, exp_q); end
      n_vec++; if (b0.tc !== (exp_q == 4'd9)) begin n_err++; $display("FAIL wrap_up_tc[%0d] got %b want %b", i, b0.tc, exp_q == 4'd9); end
      n_vec++; if (b0.co !== (exp_q == 4'd9)) begin n_err++; $display("FAIL wrap_up_co[%0d] got %b want %b", i, b0.co, exp_q == 4'd9); end
      tick();
      n_vec++; if (b0.ov !== ((i % 10) == 9)) begin n_err++; $display("FAIL wrap_up_ov[%0d] got %b want %b", i, b0.ov, (i % 10) == 9); end
    end
    b0.start = 1'b0;
    tick();
    n_vec++; if (b0.q !== 4'd2) begin n_err++; $display("FAIL hold_q got %0d want 2", b0.q); end
  endtask

  task automatic test_wrap_down();
    b0.clr = 1'b1; tick(); b0.clr = 1'b0;
    b0.up_dn = 1'b0;
    #1;
    n_vec++; if (b0.tc !== 1'b1) begin n_err++; $display("FAIL down_tc0 got %b want 1", b0.tc); end
    n_vec++; if (b0.co !== 1'b0) begin n_err++; $display("FAIL down_co_idle got %b want 0", b0.co); end
    b0.start = 1'b1;
    #1;
    n_vec++; if (b0.co !== 1'b1) begin n_err++; $display("FAIL down_co got %b want 1", b0.co); end
    tick();
    n_vec++; if (b0.q !== 4'd9) begin n_err++; $display("FAIL down_q got %0d want 9", b0.q); end
    n_vec++; if (b0.ov !== 1'b1) begin n_err++; $display("FAIL down_ov got %b want 1", b0.ov); end
    n_vec++; if (b0.tc !== 1'b0) begin n_err++; $display("FAIL down_tc9 got %b want 0", b0.tc); end
    b0.start = 1'b0;
    tick();
    n_vec++; if (b0.ov !== 1'b0) begin n_err++; $display("FAIL down_ov_pulse got %b want 0", b0.ov); end
    b0.up_dn = 1'b1;
    tick();
    n_vec++; if (b0.q !== 4'd9) begin n_err++; $display("FAIL dir_change_q got %0d want 9", b0.q); end
    n_vec++; if (b0.tc !== 1'b1) begin n_err++; $display("FAIL dir_change_tc got %b want 1", b0.tc); end
  endtask

  task automatic test_load_priority();
    b0.load = 1'b1; b0.load_val = 4'd12;
    tick();
    n_vec++; if (b0.q !== 4'd9) begin n_err++; $display("FAIL load_clamp got %0d want 9", b0.q); end
    b0.clr = 1'b1; b0.start = 1'b1;
    tick();
    n_vec++; if (b0.q !== 4'd0) begin n_err++; $display("FAIL clr_over_load got %0d want 0", b0.q); end
    b0.clr = 1'b0; b0.load_val = 4'd5;
    tick();
    n_vec++; if (b0.q !== 4'd5) begin n_err++; $display("FAIL load_over_step got %0d want 5", b0.q); end
    b0.load = 1'b0;
    tick();
    n_vec++; if (b0.q !== 4'd6) begin n_err++; $display("FAIL step_after_load got %0d want 6", b0.q); end
    b0.start = 1'b0; b0.load = 1'b1; b0.load_val = 4'd9;
    tick();
    n_vec++; if (b0.q !== 4'd9) begin n_err++; $display("FAIL load_max got %0d want 9", b0.q); end
    b0.load = 1'b0;
  endtask

  task automatic test_saturate();
    bs.clr = 1'b1; tick(); bs.clr = 1'b0;
    bs.start = 1'b1; bs.up_dn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_vec++; if (bs.q !== 4'(i)) begin n_err++; $display("FAIL sat_up_q[%0d] got %0d want %0d", i, bs.q, i); end
      n_vec++; if ({bs.sat, bs.ov} !== 2'b00) begin n_err++; $display("FAIL sat_up_flags[%0d] got %b want 00", i, {bs.sat, bs.ov}); end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (bs.q !== 4'd9) begin n_err++; $display("FAIL sat_hold_q[%0d] got %0d want 9", i, bs.q); end
      n_vec++; if ({bs.sat, bs.ov} !== 2'b10) begin n_err++; $display("FAIL sat_hold_flags[%0d] got %b want 10", i, {bs.sat, bs.ov}); end
    end
    bs.clr = 1'b1;
    tick();
    n_vec++; if ({bs.q, bs.sat} !== {4'd0, 1'b0}) begin n_err++; $display("FAIL sat_clr got q=%0d sat=%b want q=0 sat=0", bs.q, bs.sat); end
    bs.clr = 1'b0; bs.up_dn = 1'b0;
    tick();
    n_vec++; if ({bs.q, bs.sat} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL sat_down got q=%0d sat=%b want q=0 sat=1", bs.q, bs.sat); end
    bs.start = 1'b0;
    tick();
    n_vec++; if (bs.sat !== 1'b1) begin n_err++; $display("FAIL sat_sticky got %b want 1", bs.sat); end
    bs.load = 1'b1; bs.load_val = 4'd3;
    tick();
    n_vec++; if ({bs.q, bs.sat} !== {4'd3, 1'b0}) begin n_err++; $display("FAIL sat_load got q=%0d sat=%b want q=3 sat=0", bs.q, bs.sat); end
    bs.load = 1'b0;
  endtask

  task automatic test_cascade();
    bc0.clr = 1'b1; bc1.clr = 1'b1; tick();
    bc0.clr = 1'b0; bc1.clr = 1'b0;
    bc0.start = 1'b1; bc1.start = 1'b1; bc0.up_dn = 1'b1; bc1.up_dn = 1'b1; bc0.ci = 1'b1;
    ov_cnt = 0;
    #1;
    for (int i = 0; i < 100; i++) begin
      n_vec++;
      if ({bc1.q, bc0.q} !== {4'(i / 10), 4'(i % 10)}) begin
        n_err++; $display("FAIL cascade_q[%0d] got %0d%0d want %0d", i, bc1.q, bc0.q, i);
      end
      tick();
      if (bc1.ov === 1'b1) ov_cnt++;
    end
    n_vec++; if ({bc1.q, bc0.q} !== 8'h00) begin n_err++; $display("FAIL cascade_wrap got %0d%0d want 00", bc1.q, bc0.q); end
    n_vec++; if (ov_cnt !== 1) begin n_err++; $display("FAIL cascade_ov_count got %0d want 1", ov_cnt); end
    bc0.start = 1'b0; bc1.start = 1'b0;
  endtask

  task automatic test_full_range();
    bf.load = 1'b1; bf.load_val = 4'd14;
    tick();
    bf.load = 1'b0; bf.start = 1'b1; bf.up_dn = 1'b1;
    tick();
    n_vec++; if ({bf.q, bf.tc} !== {4'd15, 1'b1}) begin n_err++; $display("FAIL full_top got q=%0d tc=%b want q=15 tc=1", bf.q, bf.tc); end
    tick();
    n_vec++; if ({bf.q, bf.ov} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL full_wrap got q=%0d ov=%b want q=0 ov=1", bf.q, bf.ov); end
    bf.up_dn = 1'b0;
    tick();
    n_vec++; if ({bf.q, bf.ov} !== {4'd15, 1'b1}) begin n_err++; $display("FAIL full_down got q=%0d ov=%b want q=15 ov=1", bf.q, bf.ov); end
    bf.start = 1'b0; bf.load = 1'b1; bf.load_val = 4'd15;
    tick();
    n_vec++; if (bf.q !== 4'd15) begin n_err++; $display("FAIL full_load got %0d want 15", bf.q); end
    bf.load = 1'b0;
  endtask

  task automatic test_reset_mid();
    b0.load = 1'b1; b0.load_val = 4'd7;
    bs.load = 1'b1; bs.load_val = 4'd9;
    tick();
    bs.load = 1'b0; bs.start = 1'b1; bs.up_dn = 1'b1;
    tick();
    n_vec++; if ({b0.q, bs.sat} !== {4'd7, 1'b1}) begin n_err++; $display("FAIL pre_reset got q=%0d sat=%b want q=7 sat=1", b0.q, bs.sat); end
    rst = 1'b0; b0.load_val = 4'd3; b0.start = 1'b1; b0.up_dn = 1'b1;
    tick();
    n_vec++; if ({b0.q, b0.ov, b0.sat} !== {4'd0, 2'b00}) begin n_err++; $display("FAIL mid_reset got q=%0d ov=%b sat=%b want 0 0 0", b0.q, b0.ov, b0.sat); end
    n_vec++; if ({bs.q, bs.sat} !== {4'd0, 1'b0}) begin n_err++; $display("FAIL mid_reset_sat got q=%0d sat=%b want 0 0", bs.q, bs.sat); end
    rst = 1'b1; b0.load = 1'b0; bs.start = 1'b0;
    tick();
    n_vec++; if (b0.q !== 4'd1) begin n_err++; $display("FAIL resume got %0d want 1", b0.q); end
    b0.start = 1'b0;
  endtask

  initial begin
    b0.start = 1'b0;  b0.ci = 1'b1;  b0.up_dn = 1'b1;  b0.clr = 1'b0;  b0.load = 1'b0;  b0.load_val = 4'd0;
    bs.start = 1'b0;  bs.ci = 1'b1;  bs.up_dn = 1'b1;  bs.clr = 1'b0;  bs.load = 1'b0;  bs.load_val = 4'd0;
    bc0.start = 1'b0; bc0.ci = 1'b1; bc0.up_dn = 1'b1; bc0.clr = 1'b0; bc0.load = 1'b0; bc0.load_val = 4'd0;
    bc1.start = 1'b0; bc1.up_dn = 1'b1; bc1.clr = 1'b0; bc1.load = 1'b0; bc1.load_val = 4'd0;
    bf.start = 1'b0;  bf.ci = 1'b1;  bf.up_dn = 1'b1;  bf.clr = 1'b0;  bf.load = 1'b0;  bf.load_val = 4'd0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load_priority();
    test_saturate();
    test_cascade();
    test_full_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
